// File: rtl/aud_pkg.sv
// aud_pkg: shared defaults and the stereo frame type for the DAC audio path.
package aud_pkg;
    localparam int AUD_WIDTH = 16;
    localparam int AUD_DEPTH = 8;
    typedef struct packed {
        logic [AUD_WIDTH-1:0] l, r;
    } stereo_t;
endpackage

// File: rtl/aud_sync_fifo.sv
// aud_sync_fifo: single-clock FIFO with level counter; flush beats push and pop.
module aud_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_bclk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_wdata,
    output logic [DW-1:0]            o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    assign o_full  = o_level == (AW+1)'(DEPTH);
    assign o_empty = o_level == '0;
    assign push    = i_push & !o_full & !i_flush;
    assign pop     = i_pop & !o_empty & !i_flush;
    assign o_rdata = mem[rd_ptr];
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            o_level <= o_level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge i_bclk) begin
        if (push) mem[wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/aud_dac_frame_buffer.sv
// aud_dac_frame_buffer: stereo frame FIFO feeding the I2S DAC serializer.
// One frame is popped per DACLRCK rise and held so L and R always come from the same frame.
module aud_dac_frame_buffer
    import aud_pkg::*;
#(
    parameter int WIDTH            = AUD_WIDTH,
    parameter int DEPTH            = AUD_DEPTH,
    parameter int HOLD_ON_UNDERRUN = 1,
    parameter int CNT_W            = 8
) (
    input  logic                   i_bclk,
    input  logic                   i_rst_n,
    input  logic                   i_daclrck,
    input  logic                   i_en,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [WIDTH-1:0]       i_data_l,
    input  logic [WIDTH-1:0]       i_data_r,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_dac_l,
    output logic [WIDTH-1:0]       o_dac_r,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_underrun,
    output logic [CNT_W-1:0]       o_underrun_cnt,
    input  logic                   i_clr_status
);
    logic               lrck_d, rise, pop_req, underrun, full, empty;
    logic [2*WIDTH-1:0] head;
    assign rise     = !lrck_d & i_daclrck;
    assign pop_req  = rise & i_en & !i_flush;
    assign underrun = pop_req & empty;
    assign o_ready  = !full;
    aud_sync_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_bclk  (i_bclk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (i_valid & o_ready),
        .i_pop   (pop_req),
        .i_wdata ({i_data_l, i_data_r}),
        .o_rdata (head),
        .o_level (o_level),
        .o_full  (full),
        .o_empty (empty)
    );
    // lrck_d resets high so a high LRCK at release is not mistaken for a rise
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d         <= 1'b1;
            o_dac_l        <= '0;
            o_dac_r        <= '0;
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            lrck_d <= i_daclrck;
            if (!i_en) {o_dac_l, o_dac_r} <= '0;
            else if (pop_req & !empty) {o_dac_l, o_dac_r} <= head;
            else if (underrun & (HOLD_ON_UNDERRUN == 0)) {o_dac_l, o_dac_r} <= '0;
            if (i_clr_status) begin
                o_underrun     <= underrun;
                o_underrun_cnt <= CNT_W'(underrun);
            end else if (underrun) begin
                o_underrun     <= 1'b1;
                o_underrun_cnt <= o_underrun_cnt + CNT_W'(o_underrun_cnt != '1);
            end
        end
    end
endmodule

// File: tb/tb_aud_dac_frame_buffer.sv
// tb_aud_dac_frame_buffer: directed checks of frame pops, underruns, full, enable, flush and reset.
module tb_aud_dac_frame_buffer;
    import aud_pkg::*;
    logic        i_bclk = 1'b0;
    logic        i_rst_n, i_daclrck, i_en, i_flush, i_valid, i_clr_status;
    logic [15:0] i_data_l, i_data_r, o_dac_l, o_dac_r;
    logic        o_ready, o_underrun;
    logic [3:0]  o_level;
    logic [7:0]  o_underrun_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    stereo_t     f;

    aud_dac_frame_buffer dut (
        .i_bclk(i_bclk), .i_rst_n(i_rst_n), .i_daclrck(i_daclrck), .i_en(i_en),
        .i_flush(i_flush), .i_valid(i_valid), .i_data_l(i_data_l), .i_data_r(i_data_r),
        .o_ready(o_ready), .o_dac_l(o_dac_l), .o_dac_r(o_dac_r), .o_level(o_level),
        .o_underrun(o_underrun), .o_underrun_cnt(o_underrun_cnt), .i_clr_status(i_clr_status)
    );

    always #5 i_bclk = ~i_bclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_bclk);
    endtask

    task automatic lo();
        i_daclrck = 1'b0;
        cyc(4);
    endtask

    task automatic hi_start();
        i_daclrck = 1'b1;
        cyc(1);
    endtask

    task automatic period();
        lo();
        hi_start();
        cyc(3);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        i_valid = 1'b1;
        i_data_l = l;
        i_data_r = r;
        cyc(1);
        i_valid = 1'b0;
    endtask

    task automatic chk_dac(input string tag, input logic [15:0] l, input logic [15:0] r);
        f = '{l: l, r: r};
        chk(tag, {o_dac_l, o_dac_r}, f);
    endtask

    initial begin
        i_rst_n = 1'b0; i_daclrck = 1'b1; i_en = 1'b0; i_flush = 1'b0;
        i_valid = 1'b0; i_clr_status = 1'b0; i_data_l = '0; i_data_r = '0;
        cyc(2);
        chk_dac("rst_dac", 16'h0, 16'h0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_flag", 32'(o_underrun), 32'd0);
        chk("rst_cnt", 32'(o_underrun_cnt), 32'd0);
        i_rst_n = 1'b1;
        i_en = 1'b1;
        // 1: empty FIFO, three LRCK periods -> three underruns
        repeat (3) period();
        chk_dac("t1_dac", 16'h0, 16'h0);
        chk("t1_flag", 32'(o_underrun), 32'd1);
        chk("t1_cnt", 32'(o_underrun_cnt), 32'd3);
        chk("t1_ready", 32'(o_ready), 32'd1);
        i_clr_status = 1'b1; cyc(1); i_clr_status = 1'b0;
        chk("clr_flag", 32'(o_underrun), 32'd0);
        chk("clr_cnt", 32'(o_underrun_cnt), 32'd0);
        // 2: two frames then underrun with hold
        push(16'h1111, 16'hAAAA);
        push(16'h2222, 16'hBBBB);
        chk("t2_level", 32'(o_level), 32'd2);
        lo();
        chk_dac("t2_before", 16'h0, 16'h0);
        hi_start();
        chk_dac("t2_f0", 16'h1111, 16'hAAAA);
        chk("t2_level1", 32'(o_level), 32'd1);
        cyc(3);
        lo();
        chk_dac("t2_f0_stable", 16'h1111, 16'hAAAA);
        hi_start();
        chk_dac("t2_f1", 16'h2222, 16'hBBBB);
        chk("t2_level0", 32'(o_level), 32'd0);
        cyc(3);
        period();
        chk_dac("t2_hold", 16'h2222, 16'hBBBB);
        chk("t2_cnt", 32'(o_underrun_cnt), 32'd1);
        chk("t2_flag", 32'(o_underrun), 32'd1);
        // 3: fill to full, extra valid ignored, one pop frees a slot
        for (int k = 0; k < 8; k++) push(16'h0100 + 16'(k), 16'h0200 + 16'(k));
        chk("t3_level8", 32'(o_level), 32'd8);
        chk("t3_ready0", 32'(o_ready), 32'd0);
        i_valid = 1'b1; i_data_l = 16'hDEAD; i_data_r = 16'hBEEF;
        cyc(2);
        chk("t3_ignored", 32'(o_level), 32'd8);
        i_valid = 1'b0;
        lo();
        hi_start();
        chk("t3_level7", 32'(o_level), 32'd7);
        chk("t3_ready1", 32'(o_ready), 32'd1);
        chk_dac("t3_f0", 16'h0100, 16'h0200);
        cyc(3);
        // 4: drain to level 3, then push coincident with a pop
        repeat (4) period();
        chk("t4_level3", 32'(o_level), 32'd3);
        chk_dac("t4_f4", 16'h0104, 16'h0204);
        lo();
        i_daclrck = 1'b1;
        i_valid = 1'b1; i_data_l = 16'h3333; i_data_r = 16'hCCCC;
        cyc(1);
        i_valid = 1'b0;
        chk("t4_level_same", 32'(o_level), 32'd3);
        chk_dac("t4_f5", 16'h0105, 16'h0205);
        cyc(3);
        // 5: disabled playback at level 4
        push(16'h4444, 16'hDDDD);
        chk("t5_level4", 32'(o_level), 32'd4);
        i_en = 1'b0;
        cyc(1);
        chk_dac("t5_dac0", 16'h0, 16'h0);
        repeat (5) period();
        chk("t5_level_kept", 32'(o_level), 32'd4);
        chk_dac("t5_dac0_after", 16'h0, 16'h0);
        chk("t5_cnt", 32'(o_underrun_cnt), 32'd1);
        i_en = 1'b1;
        lo(); hi_start();
        chk_dac("t5_f6", 16'h0106, 16'h0206);
        chk("t5_level3", 32'(o_level), 32'd3);
        cyc(3);
        lo(); hi_start();
        chk_dac("t5_f7", 16'h0107, 16'h0207);
        cyc(3);
        lo(); hi_start();
        chk_dac("t5_pushed", 16'h3333, 16'hCCCC);
        chk("t5_level1", 32'(o_level), 32'd1);
        cyc(3);
        // 6: flush at level 5 coincident with a rise
        for (int k = 0; k < 4; k++) push(16'h5000 + 16'(k), 16'h6000 + 16'(k));
        chk("t6_level5", 32'(o_level), 32'd5);
        lo();
        i_daclrck = 1'b1; i_flush = 1'b1;
        cyc(1);
        i_flush = 1'b0;
        chk("t6_level0", 32'(o_level), 32'd0);
        chk_dac("t6_dac_kept", 16'h3333, 16'hCCCC);
        chk("t6_cnt", 32'(o_underrun_cnt), 32'd1);
        cyc(3);
        period();
        chk("t6_underrun", 32'(o_underrun_cnt), 32'd2);
        chk_dac("t6_hold", 16'h3333, 16'hCCCC);
        i_clr_status = 1'b1; cyc(1); i_clr_status = 1'b0;
        chk("t6_clr_flag", 32'(o_underrun), 32'd0);
        chk("t6_clr_cnt", 32'(o_underrun_cnt), 32'd0);
        // clear coinciding with an underrun leaves flag=1, count=1
        lo();
        i_daclrck = 1'b1; i_clr_status = 1'b1;
        cyc(1);
        i_clr_status = 1'b0;
        chk("clr_ur_flag", 32'(o_underrun), 32'd1);
        chk("clr_ur_cnt", 32'(o_underrun_cnt), 32'd1);
        cyc(3);
        // counter saturates at all-ones
        repeat (260) period();
        chk("sat_cnt", 32'(o_underrun_cnt), 32'd255);
        // async reset mid-frame
        push(16'h9999, 16'h9999);
        chk("ar_level1", 32'(o_level), 32'd1);
        lo();
        cyc(1);
        #1 i_rst_n = 1'b0;
        #1;
        chk_dac("ar_dac", 16'h0, 16'h0);
        chk("ar_level", 32'(o_level), 32'd0);
        chk("ar_cnt", 32'(o_underrun_cnt), 32'd0);
        chk("ar_ready", 32'(o_ready), 32'd1);
        cyc(1);
        i_daclrck = 1'b1;
        cyc(1);
        i_rst_n = 1'b1;
        cyc(1);
        chk("ar_no_rise", 32'(o_underrun_cnt), 32'd0);
        push(16'h7777, 16'h8888);
        lo(); hi_start();
        chk_dac("ar_first_pop", 16'h7777, 16'h8888);
        chk("ar_level0", 32'(o_level), 32'd0);
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
